// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types
//
// Purpose: types shared by the UART receive path.
//   rx_flags_t  : tag bits carried with every buffered receive entry
//   parity_e    : line parity setting
//   stop_bits_e : number of stop bits
package uart_pkg;

   typedef struct packed {
      logic brk;
      logic err;
   } rx_flags_t;

   typedef enum logic [1:0] {
      PARITY_NONE = 2'd0,
      PARITY_EVEN = 2'd1,
      PARITY_ODD  = 2'd2
   } parity_e;

   typedef enum logic {
      STOP_1 = 1'b0,
      STOP_2 = 1'b1
   } stop_bits_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - generic show-ahead synchronous FIFO
//
// Purpose: single-clock FIFO whose head entry is always visible on rdata_o.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (pointers/count only)
//   push_i    : write wdata_i (taken if not full, or if a pop happens too)
//   wdata_i   : entry to write
//   pop_i     : discard head entry (ignored when empty)
//   flush_i   : empty the FIFO; overrides push and pop
//   rdata_o   : head entry, meaningful only when empty_o=0
//   count_o   : occupancy 0..Depth
//   full_o    : count_o == Depth
//   empty_o   : count_o == 0
module sync_fifo
   import uart_pkg::*;
#(
   parameter int Width = 10,
   parameter int Depth = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [Width-1:0]         wdata_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [Width-1:0]         rdata_o,
   output logic [$clog2(Depth):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(Depth);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DepthCnt = CW'(Depth);

   if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo: Depth must be a power of two and at least 2");
   end

   logic [Width-1:0] mem_q [Depth];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == DepthCnt);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign do_pop  = pop_i & ~empty_o & ~flush_i;
   assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Power-of-two depth: pointers wrap by natural overflow.
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_d = count_q + 1'b1;
         else if (!do_push && do_pop) count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; count/empty gate its visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - UART receive buffer with break coalescing and overrun tracking
//
// Purpose: captures receiver result pulses into a FIFO of tagged entries and
// presents them through a valid/ready interface.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   rx_data, rx_valid           : good character pulse
//   rx_break                    : break frame pulse (stored with data 0)
//   rx_error                    : framing/parity error pulse (stored with data)
//   out_data/out_break/out_error: head entry, forced to 0 while out_valid=0
//   out_valid, out_ready        : head handshake
//   flush                       : drop all buffered entries
//   clear_overrun               : clear overrun flag and counter
//   count                       : occupancy 0..Depth
//   overrun, overrun_count      : sticky drop flag, saturating drop counter
module uart_rx_buffer
   import uart_pkg::*;
#(
   parameter int DataBits       = 8,
   parameter int Depth          = 16,
   parameter int OverrunCntBits = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DataBits-1:0]       rx_data,
   input  logic                      rx_valid,
   input  logic                      rx_break,
   input  logic                      rx_error,
   output logic [DataBits-1:0]       out_data,
   output logic                      out_break,
   output logic                      out_error,
   output logic                      out_valid,
   input  logic                      out_ready,
   input  logic                      flush,
   input  logic                      clear_overrun,
   output logic [$clog2(Depth):0]    count,
   output logic                      overrun,
   output logic [OverrunCntBits-1:0] overrun_count
);

   localparam int EW = DataBits + 2;

   if (DataBits < 5 || DataBits > 9) begin : g_bad_databits
      $error("uart_rx_buffer: DataBits must be in 5..9");
   end

   typedef struct packed {
      rx_flags_t           flags;
      logic [DataBits-1:0] data;
   } rx_entry_t;

   rx_entry_t                 evt_entry;
   rx_entry_t                 head_entry;
   logic                      evt_any;
   logic                      coalesced;
   logic                      want_push;
   logic                      push;
   logic                      pop;
   logic                      drop;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [EW-1:0]             fifo_rdata;

   logic                      last_was_break_q, last_was_break_d;
   logic                      overrun_q, overrun_d;
   logic [OverrunCntBits-1:0] overrun_cnt_q, overrun_cnt_d;

   // Pulses should be exclusive; if not, valid beats break beats error.
   always_comb begin
      evt_entry = '0;
      if (rx_valid) begin
         evt_entry.data = rx_data;
      end else if (rx_break) begin
         evt_entry.flags.brk = 1'b1;
      end else if (rx_error) begin
         evt_entry.flags.err = 1'b1;
         evt_entry.data      = rx_data;
      end
   end

   assign evt_any   = rx_valid | rx_break | rx_error;
   assign coalesced = evt_entry.flags.brk & last_was_break_q;
   // Flush discards an arriving event outright, so it can never be an overrun.
   assign want_push = evt_any & ~coalesced & ~flush;
   assign pop       = out_valid & out_ready & ~flush;
   assign push      = want_push & (~fifo_full | pop);
   assign drop      = want_push & fifo_full & ~pop;

   always_comb begin
      last_was_break_d = last_was_break_q;
      overrun_d        = overrun_q;
      overrun_cnt_d    = overrun_cnt_q;

      // Coalescing history follows every event, even dropped or flushed ones.
      if (evt_any) last_was_break_d = evt_entry.flags.brk;

      // A drop in the clear cycle wins: it becomes the first counted drop.
      if (drop) begin
         overrun_d = 1'b1;
         if (clear_overrun)          overrun_cnt_d = OverrunCntBits'(1);
         else if (&overrun_cnt_q)    overrun_cnt_d = overrun_cnt_q;
         else                        overrun_cnt_d = overrun_cnt_q + 1'b1;
      end else if (clear_overrun) begin
         overrun_d     = 1'b0;
         overrun_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // Starting as "last was break" hides the break from a line held low at power-up.
         last_was_break_q <= 1'b1;
         overrun_q        <= 1'b0;
         overrun_cnt_q    <= '0;
      end else begin
         last_was_break_q <= last_was_break_d;
         overrun_q        <= overrun_d;
         overrun_cnt_q    <= overrun_cnt_d;
      end
   end

   sync_fifo #(
      .Width (EW),
      .Depth (Depth)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (evt_entry),
      .pop_i   (pop),
      .flush_i (flush),
      .rdata_o (fifo_rdata),
      .count_o (count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign head_entry    = fifo_rdata;
   assign out_valid     = ~fifo_empty;
   assign out_data      = out_valid ? head_entry.data      : '0;
   assign out_break     = out_valid ? head_entry.flags.brk : 1'b0;
   assign out_error     = out_valid ? head_entry.flags.err : 1'b0;
   assign overrun       = overrun_q;
   assign overrun_count = overrun_cnt_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - self-checking bench for uart_rx_buffer
module tb_uart_rx_buffer;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CNTW  = 8;
   localparam int CMAX  = 255;

   logic            clk = 1'b0;
   logic            rst;
   logic [DW-1:0]   rx_data;
   logic            rx_valid, rx_break, rx_error;
   logic [DW-1:0]   out_data;
   logic            out_break, out_error, out_valid;
   logic            out_ready, flush, clear_overrun;
   logic [4:0]      count;
   logic            overrun;
   logic [CNTW-1:0] overrun_count;

   int errors = 0;
   int checks = 0;

   // Reference state: FIFO contents as a queue of {brk, err, data}.
   logic [DW+1:0] mq[$];
   bit            m_lwb;
   bit            m_ovr;
   int            m_ovc;

   always #5 clk = ~clk;

   uart_rx_buffer #(.DataBits(DW), .Depth(DEPTH), .OverrunCntBits(CNTW)) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_break      (rx_break),
      .rx_error      (rx_error),
      .out_data      (out_data),
      .out_break     (out_break),
      .out_error     (out_error),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .flush         (flush),
      .clear_overrun (clear_overrun),
      .count         (count),
      .overrun       (overrun),
      .overrun_count (overrun_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      mq.delete();
      m_lwb = 1'b1;
      m_ovr = 1'b0;
      m_ovc = 0;
   endtask

   task automatic check_all(input string tag);
      logic [DW+1:0] head;
      head = (mq.size() != 0) ? mq[0] : '0;
      chk({tag, ".out_valid"}, out_valid, (mq.size() != 0));
      chk({tag, ".out_data"}, out_data, head[DW-1:0]);
      chk({tag, ".out_break"}, out_break, head[DW+1]);
      chk({tag, ".out_error"}, out_error, head[DW]);
      chk({tag, ".count"}, count, mq.size());
      chk({tag, ".overrun"}, overrun, m_ovr);
      chk({tag, ".overrun_count"}, overrun_count, m_ovc);
   endtask

   // One clock cycle with the given inputs; the model advances by the rules, then all outputs are compared.
   task automatic step(input string tag, input logic v, input logic b, input logic e,
                       input logic [DW-1:0] d, input logic rdy, input logic fl, input logic clr);
      logic [DW+1:0] ent;
      bit ev, brk, coal, pop, drop;
      int pre;
      rx_valid = v; rx_break = b; rx_error = e; rx_data = d;
      out_ready = rdy; flush = fl; clear_overrun = clr;
      ev  = v | b | e;
      brk = !v && b;
      if (v)      ent = {2'b00, d};
      else if (b) ent = {2'b10, {DW{1'b0}}};
      else        ent = {2'b01, d};
      pre  = mq.size();
      pop  = (pre > 0) && rdy && !fl;
      coal = brk && m_lwb;
      drop = 0;
      @(posedge clk);
      #1;
      if (fl) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (ev && !coal) begin
            if (pre < DEPTH || pop) mq.push_back(ent);
            else drop = 1;
         end
      end
      if (ev) m_lwb = brk;
      if (drop) begin
         m_ovr = 1'b1;
         m_ovc = clr ? 1 : ((m_ovc == CMAX) ? CMAX : m_ovc + 1);
      end else if (clr) begin
         m_ovr = 1'b0;
         m_ovc = 0;
      end
      check_all(tag);
   endtask

   task automatic idle(input string tag, input logic rdy);
      step(tag, 1'b0, 1'b0, 1'b0, '0, rdy, 1'b0, 1'b0);
   endtask

   task automatic push_v(input string tag, input logic [DW-1:0] d);
      step(tag, 1'b1, 1'b0, 1'b0, d, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [DW-1:0] rd;
      rst = 1'b1;
      rx_data = '0; rx_valid = 0; rx_break = 0; rx_error = 0;
      out_ready = 0; flush = 0; clear_overrun = 0;
      m_reset();
      #2;
      check_all("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Break coalescing: first break after reset is suppressed.
      step("brk0", 1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
      chk("brk0_count", count, 0);
      push_v("c_41", 8'h41);
      for (int i = 0; i < 3; i++) step("c_brk", 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      step("c_err", 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0);
      step("c_brk2", 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("coal_count", count, 4);
      chk("coal_head", out_data, 8'h41);
      for (int i = 0; i < 4; i++) idle("c_drain", 1'b1);

      // Single character with one-cycle latency.
      push_v("single", 8'h5A);
      chk("single_valid", out_valid, 1'b1);
      chk("single_data", out_data, 8'h5A);
      idle("single_hold", 1'b0);
      idle("single_pop", 1'b1);
      chk("single_empty", count, 0);

      // Fill and overrun.
      for (int i = 0; i < DEPTH; i++) push_v("fill", DW'(i));
      for (int i = 0; i < 3; i++) push_v("ovr", 8'hEE);
      chk("fill_count", count, 16);
      chk("fill_ovr", overrun, 1'b1);
      chk("fill_ovc", overrun_count, 3);
      for (int i = 0; i < DEPTH; i++) begin
         rd = out_data;
         chk("drain_order", rd, DW'(i));
         idle("drain", 1'b1);
      end

      // Full with simultaneous pop.
      for (int i = 0; i < DEPTH; i++) push_v("refill", DW'($urandom));
      step("full_pop", 1'b1, 1'b0, 1'b0, 8'hAA, 1'b1, 1'b0, 1'b0);
      chk("full_pop_count", count, 16);
      chk("full_pop_ovc", overrun_count, 3);
      for (int i = 0; i < DEPTH - 1; i++) idle("fp_drain", 1'b1);
      chk("fp_last", out_data, 8'hAA);
      idle("fp_drain_last", 1'b1);

      // Saturation then clear racing a drop.
      step("clr", 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("clr_ovc", overrun_count, 0);
      for (int i = 0; i < DEPTH; i++) push_v("sat_fill", DW'($urandom));
      for (int i = 0; i < 300; i++) push_v("sat", DW'($urandom));
      chk("sat_ovc", overrun_count, 255);
      step("clr_race", 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
      chk("race_ovr", overrun, 1'b1);
      chk("race_ovc", overrun_count, 1);

      // Flush with a coincident event.
      step("flush0", 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) push_v("f_fill", DW'($urandom));
      step("flush_evt", 1'b1, 1'b0, 1'b0, 8'h99, 1'b1, 1'b1, 1'b0);
      chk("flush_count", count, 0);
      chk("flush_valid", out_valid, 1'b0);
      chk("flush_ovc", overrun_count, 1);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         step("rand", ($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 8) == 0,
              DW'($urandom), $urandom % 2, ($urandom % 97) == 0, ($urandom % 61) == 0);
      end

      // Asynchronous reset mid-fill.
      for (int i = 0; i < 3; i++) push_v("r_fill", DW'($urandom | 1));
      rst = 1'b1;
      #1;
      m_reset();
      check_all("async_rst");
      chk("async_rst_valid", out_valid, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step("post_rst_brk", 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      push_v("post_rst", 8'h3C);
      idle("post_rst_pop", 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
